// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port register file and its pending-write scoreboard.
package regfile_mp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_NUM_REGS   = 15;
    localparam int unsigned DEF_NUM_RD     = 3;
    localparam int unsigned DEF_CNT_WIDTH  = 2;

    // Saturation value of a pending-writer counter.
    function automatic int unsigned max_count(input int unsigned cnt_width);
        return (32'd1 << cnt_width) - 32'd1;
    endfunction

    // Bit offset of field idx in a packed bus of equal-width fields.
    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    function automatic bit index_valid(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Saturating up/down pending-writer counter for one register; flush clears it.
module regfile_sb_counter
    import regfile_mp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic [1:0]           dec,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 nonzero,
    output logic                 at_max
);

    localparam int unsigned          MAX_INT = max_count(CNT_WIDTH);
    localparam logic [CNT_WIDTH+1:0] MAX_EXT = MAX_INT[CNT_WIDTH+1:0];

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH+1:0] up;
    logic [CNT_WIDTH+1:0] dec_ext;
    logic [CNT_WIDTH+1:0] diff;

    // Two extra bits keep cnt + inc - dec free of wrap-around before clamping.
    always_comb begin
        up      = {2'b00, cnt_q} + {{(CNT_WIDTH+1){1'b0}}, inc};
        dec_ext = {{CNT_WIDTH{1'b0}}, dec};
        diff    = up - dec_ext;
        cnt_d   = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (up <= dec_ext) begin
            cnt_d = '0;
        end else if (diff >= MAX_EXT) begin
            cnt_d = MAX_EXT[CNT_WIDTH-1:0];
        end else begin
            cnt_d = diff[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = |cnt_q;
    assign at_max  = (cnt_q == MAX_EXT[CNT_WIDTH-1:0]);

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write-back ports and a pending-write scoreboard.
// Build option: REGFILE_MP_BYPASS_EN adds write-through forwarding on the read ports.
module regfile_mp_sb
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned NUM_RD     = DEF_NUM_RD,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wb0_en,
    input  logic [ADDR_WIDTH-1:0]        wb0_dest,
    input  logic [DATA_WIDTH-1:0]        wb0_value,
    input  logic                         wb1_en,
    input  logic [ADDR_WIDTH-1:0]        wb1_dest,
    input  logic [DATA_WIDTH-1:0]        wb1_value,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_dest,
    output logic                         iss_full,
    input  logic                         flush
);

    localparam int unsigned          NUM_IDX = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(max_count(CNT_WIDTH));

    logic [DATA_WIDTH-1:0] reg_value [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_busy;
    logic [NUM_REGS-1:0]   reg_full;

    // Views over the full index space; unimplemented indices read as idle zeros.
    logic [DATA_WIDTH-1:0] data_view [NUM_IDX];
    logic [NUM_IDX-1:0]    busy_view;
    logic [NUM_IDX-1:0]    full_view;

`ifdef REGFILE_MP_BYPASS_EN
    logic [NUM_REGS-1:0] reg_hit0;
    logic [NUM_REGS-1:0] reg_hit1;
    logic [NUM_REGS-1:0] reg_drain;
    logic [NUM_IDX-1:0]  hit0_view;
    logic [NUM_IDX-1:0]  hit1_view;
    logic [NUM_IDX-1:0]  drain_view;
`endif

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(r);

        logic                  hit0;
        logic                  hit1;
        logic                  inc;
        logic [1:0]            dec;
        logic [CNT_WIDTH-1:0]  cnt;
        logic [DATA_WIDTH-1:0] value_q;

        assign hit0 = wb0_en && (wb0_dest == IDX);
        assign hit1 = wb1_en && (wb1_dest == IDX);
        assign inc  = iss_en && (iss_dest == IDX) && (cnt != CNT_MAX);
        assign dec  = {1'b0, hit0} + {1'b0, hit1};

        // wb0 has priority; a colliding wb1 value is dropped but still retires its writer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                value_q <= '0;
            end else if (hit0) begin
                value_q <= wb0_value;
            end else if (hit1) begin
                value_q <= wb1_value;
            end
        end

        regfile_sb_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc),
            .dec     (dec),
            .flush   (flush),
            .cnt     (cnt),
            .nonzero (reg_busy[r]),
            .at_max  (reg_full[r])
        );

        assign reg_value[r] = value_q;

`ifdef REGFILE_MP_BYPASS_EN
        assign reg_hit0[r]  = hit0;
        assign reg_hit1[r]  = hit1;
        // Set when this cycle's writes retire every pending writer of the register.
        assign reg_drain[r] = ({2'b00, cnt} + {{(CNT_WIDTH+1){1'b0}}, inc})
                              <= {{CNT_WIDTH{1'b0}}, dec};
`endif
    end

    for (genvar k = 0; k < NUM_IDX; k++) begin : g_view
        if (index_valid(k, NUM_REGS)) begin : g_impl
            assign data_view[k] = reg_value[k];
            assign busy_view[k] = reg_busy[k];
            assign full_view[k] = reg_full[k];
`ifdef REGFILE_MP_BYPASS_EN
            assign hit0_view[k]  = reg_hit0[k];
            assign hit1_view[k]  = reg_hit1[k];
            assign drain_view[k] = reg_drain[k];
`endif
        end else begin : g_unimpl
            assign data_view[k] = '0;
            assign busy_view[k] = 1'b0;
            assign full_view[k] = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
            assign hit0_view[k]  = 1'b0;
            assign hit1_view[k]  = 1'b0;
            assign drain_view[k] = 1'b0;
`endif
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;

        assign addr = rd_addr[field_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];

        always_comb begin
            data = data_view[addr];
            busy = busy_view[addr];
`ifdef REGFILE_MP_BYPASS_EN
            // Forwarding is suppressed in reset so outputs track the cleared state.
            if (!rst) begin
                if (hit0_view[addr]) begin
                    data = wb0_value;
                end else if (hit1_view[addr]) begin
                    data = wb1_value;
                end
                if ((hit0_view[addr] || hit1_view[addr]) && drain_view[addr]) begin
                    busy = 1'b0;
                end
            end
`endif
        end

        assign rd_data[field_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = data;
        assign rd_busy[i] = busy;
    end

    assign iss_full = iss_en && full_view[iss_dest];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: hand-computed vector table, corner sequences, then random vs a model.
module tb_regfile_mp_sb;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 15;
    localparam int NRD  = 3;
    localparam int MAXC = 3;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] A = 32'hAAAA_0000;
    localparam logic [31:0] B = 32'h0000_BBBB;

    logic                  clk;
    logic                  rst;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wb0_en;
    logic [AW-1:0]         wb0_dest;
    logic [DW-1:0]         wb0_value;
    logic                  wb1_en;
    logic [AW-1:0]         wb1_dest;
    logic [DW-1:0]         wb1_value;
    logic                  iss_en;
    logic [AW-1:0]         iss_dest;
    logic                  iss_full;
    logic                  flush;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [16];
    int          m_cnt  [16];

    typedef struct {
        logic        wb0_en;
        logic [3:0]  wb0_dest;
        logic [31:0] wb0_value;
        logic        wb1_en;
        logic [3:0]  wb1_dest;
        logic [31:0] wb1_value;
        logic        iss_en;
        logic [3:0]  iss_dest;
        logic        flush;
        logic [11:0] rd_addr;
        logic [95:0] exp_data;
        logic [2:0]  exp_busy;
        logic        exp_full;
    } vec_t;

    vec_t tbl [$];
    vec_t seq [$];

    regfile_mp_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wb0_en    (wb0_en),
        .wb0_dest  (wb0_dest),
        .wb0_value (wb0_value),
        .wb1_en    (wb1_en),
        .wb1_dest  (wb1_dest),
        .wb1_value (wb1_value),
        .iss_en    (iss_en),
        .iss_dest  (iss_dest),
        .iss_full  (iss_full),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e0, input logic [3:0] d0, input logic [31:0] v0,
                                input logic e1, input logic [3:0] d1, input logic [31:0] v1,
                                input logic ie, input logic [3:0] id, input logic fl,
                                input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                                input logic [31:0] x0, input logic [31:0] x1,
                                input logic [31:0] x2, input logic [2:0] eb, input logic ef);
        vec_t v;
        v.wb0_en = e0;  v.wb0_dest = d0;  v.wb0_value = v0;
        v.wb1_en = e1;  v.wb1_dest = d1;  v.wb1_value = v1;
        v.iss_en = ie;  v.iss_dest = id;  v.flush = fl;
        v.rd_addr  = {a2, a1, a0};
        v.exp_data = {x2, x1, x0};
        v.exp_busy = eb;
        v.exp_full = ef;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
    endtask

    // Spec-level next state: count += issue - retiring writes, clamped; flush wins; wb0 wins.
    task automatic model_update();
        for (int r = 0; r < NR; r++) begin
            int inc;
            int dec;
            int n;
            inc = (iss_en && iss_dest == r && m_cnt[r] < MAXC) ? 1 : 0;
            dec = ((wb0_en && wb0_dest == r) ? 1 : 0) + ((wb1_en && wb1_dest == r) ? 1 : 0);
            n = m_cnt[r] + inc - dec;
            if (n < 0) n = 0;
            if (n > MAXC) n = MAXC;
            if (flush) n = 0;
            m_cnt[r] = n;
        end
        if (wb1_en && wb1_dest < NR) m_regs[wb1_dest] = wb1_value;
        if (wb0_en && wb0_dest < NR) m_regs[wb0_dest] = wb0_value;
    endtask

    task automatic model_expect(output logic [95:0] ed, output logic [2:0] eb, output logic ef);
        for (int i = 0; i < NRD; i++) begin
            int          a;
            logic [31:0] d;
            logic        b;
            a = int'(rd_addr[i*AW +: AW]);
            d = '0;
            b = 1'b0;
            if (a < NR) begin
                d = m_regs[a];
                b = (m_cnt[a] != 0);
                if (BYP) begin
                    int inc;
                    int dec;
                    inc = (iss_en && iss_dest == a && m_cnt[a] < MAXC) ? 1 : 0;
                    dec = ((wb0_en && wb0_dest == a) ? 1 : 0) + ((wb1_en && wb1_dest == a) ? 1 : 0);
                    if (wb0_en && wb0_dest == a) d = wb0_value;
                    else if (wb1_en && wb1_dest == a) d = wb1_value;
                    if (dec > 0 && m_cnt[a] + inc - dec <= 0) b = 1'b0;
                end
            end
            ed[i*DW +: DW] = d;
            eb[i] = b;
        end
        ef = iss_en && (iss_dest < NR) && (m_cnt[iss_dest] == MAXC);
    endtask

    task automatic cmp_out(input string name, input logic [95:0] ed, input logic [2:0] eb,
                           input logic ef);
        n_cmp++;
        if (rd_data !== ed) begin
            n_bad++;
            $display("FAIL %s rd_data got %h want %h", name, rd_data, ed);
        end
        n_cmp++;
        if (rd_busy !== eb) begin
            n_bad++;
            $display("FAIL %s rd_busy got %b want %b", name, rd_busy, eb);
        end
        n_cmp++;
        if (iss_full !== ef) begin
            n_bad++;
            $display("FAIL %s iss_full got %b want %b", name, iss_full, ef);
        end
    endtask

    task automatic set_idle();
        wb0_en = 1'b0; wb0_dest = '0; wb0_value = '0;
        wb1_en = 1'b0; wb1_dest = '0; wb1_value = '0;
        iss_en = 1'b0; iss_dest = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        wb0_en = v.wb0_en; wb0_dest = v.wb0_dest; wb0_value = v.wb0_value;
        wb1_en = v.wb1_en; wb1_dest = v.wb1_dest; wb1_value = v.wb1_value;
        iss_en = v.iss_en; iss_dest = v.iss_dest; flush = v.flush;
        rd_addr = v.rd_addr;
        @(negedge clk);
        cmp_out(name, v.exp_data, v.exp_busy, v.exp_full);
        step();
    endtask

    initial begin
        logic [95:0] ed;
        logic [2:0]  eb;
        logic        ef;

        model_reset();
        rst = 1'b1;
        set_idle();
        // Outputs must show the cleared state while reset is held, whatever the inputs do.
        wb0_en = 1'b1; wb0_dest = 4'd5; wb0_value = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_dest = 4'd2;
        rd_addr = {4'd15, 4'd2, 4'd5};
        repeat (2) @(posedge clk);
        #1;
        cmp_out("reset_hold", '0, 3'b000, 1'b0);
        set_idle();
        rd_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table: {wb0, wb1, issue, flush, read addrs, expected data/busy/full}.
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd0,4'd5,4'd15, Z,Z,Z, 3'b000, N));
        tbl.push_back(mk(Y,4'd5,A, Y,4'd5,B, N,4'd0, N, 4'd5,4'd5,4'd5,
                         BYP ? A : Z, BYP ? A : Z, BYP ? A : Z, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd5,4'd0,4'd5, A,Z,A, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd2, N, 4'd2,4'd2,4'd2, Z,Z,Z, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd2, N, 4'd2,4'd2,4'd2, Z,Z,Z, 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd2, N, 4'd2,4'd2,4'd2, Z,Z,Z, 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd2, N, 4'd2,4'd2,4'd2, Z,Z,Z, 3'b111, Y));
        tbl.push_back(mk(Y,4'd2,32'h11, N,4'd0,Z, N,4'd0, N, 4'd2,4'd2,4'd2,
                         BYP ? 32'h11 : Z, BYP ? 32'h11 : Z, BYP ? 32'h11 : Z, 3'b111, N));
        tbl.push_back(mk(Y,4'd2,32'h22, N,4'd0,Z, N,4'd0, N, 4'd2,4'd2,4'd2,
                         BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11,
                         3'b111, N));
        tbl.push_back(mk(Y,4'd2,32'h33, N,4'd0,Z, N,4'd0, N, 4'd2,4'd2,4'd2,
                         BYP ? 32'h33 : 32'h22, BYP ? 32'h33 : 32'h22, BYP ? 32'h33 : 32'h22,
                         BYP ? 3'b000 : 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd2,4'd2,4'd2,
                         32'h33,32'h33,32'h33, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd7, N, 4'd7,4'd2,4'd5, Z,32'h33,A, 3'b000, N));
        tbl.push_back(mk(Y,4'd7,32'h77, N,4'd0,Z, Y,4'd7, N, 4'd7,4'd7,4'd7,
                         BYP ? 32'h77 : Z, BYP ? 32'h77 : Z, BYP ? 32'h77 : Z, 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd7,4'd7,4'd7,
                         32'h77,32'h77,32'h77, 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd1, N, 4'd1,4'd4,4'd7, Z,Z,32'h77, 3'b100, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd4, N, 4'd1,4'd4,4'd7, Z,Z,32'h77, 3'b101, N));
        tbl.push_back(mk(N,4'd0,Z, Y,4'd4,32'h1234, N,4'd0, Y, 4'd1,4'd4,4'd7,
                         Z, BYP ? 32'h1234 : Z, 32'h77, BYP ? 3'b101 : 3'b111, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd1,4'd4,4'd7,
                         Z,32'h1234,32'h77, 3'b000, N));
        tbl.push_back(mk(Y,4'd15,32'hDEAD, Y,4'd15,32'hBEEF, Y,4'd15, N, 4'd15,4'd15,4'd15,
                         Z,Z,Z, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd2, N, 4'd15,4'd5,4'd2, Z,A,32'h33, 3'b000, N));
        tbl.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd2,4'd15,4'd4,
                         32'h33,Z,32'h1234, 3'b001, N));

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Asynchronous reset mid-run, between clock edges.
        run_vec("pre_rst", mk(Y,4'd3,32'h55, N,4'd0,Z, Y,4'd6, N, 4'd3,4'd6,4'd3,
                              BYP ? 32'h55 : Z, Z, BYP ? 32'h55 : Z, 3'b000, N));
        set_idle();
        #1;
        cmp_out("r3_written", {32'h55, 32'h0, 32'h55}, 3'b010, 1'b0);
        rst = 1'b1;
        #1;
        cmp_out("async_rst", '0, 3'b000, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Saturation, flush overriding issue, and clamp at zero on a double retire.
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, N, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b000, N));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, N, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b111, N));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, N, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b111, N));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, N, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b111, Y));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, Y, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b111, Y));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, Y,4'd9, N, 4'd9,4'd9,4'd9, Z,Z,Z, 3'b000, N));
        seq.push_back(mk(Y,4'd9,32'h91, Y,4'd9,32'h92, N,4'd0, N, 4'd9,4'd9,4'd9,
                         BYP ? 32'h91 : Z, BYP ? 32'h91 : Z, BYP ? 32'h91 : Z,
                         BYP ? 3'b000 : 3'b111, N));
        seq.push_back(mk(N,4'd0,Z, N,4'd0,Z, N,4'd0, N, 4'd9,4'd9,4'd9,
                         32'h91,32'h91,32'h91, 3'b000, N));
        foreach (seq[i]) run_vec($sformatf("seq%0d", i), seq[i]);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            wb0_en    = ($urandom_range(0, 9) < 4);
            wb0_dest  = AW'($urandom_range(0, 15));
            wb0_value = $urandom;
            wb1_en    = ($urandom_range(0, 9) < 4);
            wb1_dest  = ($urandom_range(0, 3) == 0) ? wb0_dest : AW'($urandom_range(0, 15));
            wb1_value = $urandom;
            iss_en    = ($urandom_range(0, 9) < 5);
            iss_dest  = AW'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 15) == 0);
            rd_addr[0 +: AW]    = ($urandom_range(0, 2) == 0) ? wb0_dest : AW'($urandom_range(0, 15));
            rd_addr[AW +: AW]   = ($urandom_range(0, 2) == 0) ? iss_dest : AW'($urandom_range(0, 15));
            rd_addr[2*AW +: AW] = AW'($urandom_range(0, 15));
            @(negedge clk);
            model_expect(ed, eb, ef);
            cmp_out($sformatf("rand%0d", c), ed, eb, ef);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parameterised multi-port general-purpose register file for the ARM ID stage.
- Holds R0..R(NUM_REGS-1); PC is held elsewhere.
- Adds NUM_RD read ports, two write-back ports with a fixed priority, and a per-register pending-write scoreboard with a flush.
- Hazard-detection logic uses the per-read-port busy flags to stall the pipeline.

Parameters:
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 4, register index width
- NUM_REGS, 15, number of implemented registers; indices >= NUM_REGS are unimplemented
- NUM_RD, 3, number of read ports (Rn, Rm, Rs)
- CNT_WIDTH, 2, width of each per-register pending-writer counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data
- rd_busy  out  NUM_RD  1 = addressed register has a pending writer
- wb0_en  in  1  write port 0 enable (ALU path, high priority)
- wb0_dest  in  ADDR_WIDTH  write port 0 destination
- wb0_value  in  DATA_WIDTH  write port 0 data
- wb1_en  in  1  write port 1 enable (load path)
- wb1_dest  in  ADDR_WIDTH  write port 1 destination
- wb1_value  in  DATA_WIDTH  write port 1 data
- iss_en  in  1  instruction issue with a register destination
- iss_dest  in  ADDR_WIDTH  destination of the issued instruction
- iss_full  out  1  combinational; iss_dest counter is at maximum, issue will be ignored
- flush  in  1  synchronous; clears all pending counters

Behaviour:
- Reset: all registers 0, all counters 0. Combinational outputs follow this state immediately, so rd_data = 0, rd_busy = 0, iss_full = 0 while rst is high.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]]. An unimplemented index returns 0 with busy 0.
- Writes commit on posedge clk when the port's enable is high and its dest < NUM_REGS.
  - Same dest on both ports in one cycle: wb0 wins, wb1 is dropped, and the counter decrements once per port.
  - A write to an unimplemented index is ignored and does not touch any counter.
- Without the optional feature, a read in the same cycle as a write returns the old value. The new value is visible from the next cycle.
- Counter update per register r on posedge, computed as next = cnt + inc - dec:
  - inc = 1 when iss_en, iss_dest == r, and cnt is not at maximum.
  - dec = number of enabled write ports targeting r, 0 to 2.
  - The result clamps at 0 and at the maximum 2^CNT_WIDTH-1.
  - Issue and write to r in the same cycle leave the count unchanged.
- Busy: rd_busy[i] = (cnt[rd_addr[i]] != 0).
- iss_full = iss_en and cnt[iss_dest] == max. The issue is dropped and the stage must stall.
- flush: all counters go to 0 on posedge.
  - flush overrides any issue and any decrement in the same cycle.
  - Register writes in that cycle still commit.
- Reset mid-operation: registers and counters clear asynchronously. Pending writes in that cycle are lost.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-through forwarding.
  - rd_data[i] = wb0_value if wb0_en and wb0_dest == rd_addr[i]; else wb1_value if wb1_en and wb1_dest == rd_addr[i]; else the stored value. Only implemented indices are forwarded.
  - rd_busy[i] is masked to 0 when a forwarded write hits port i and that write's decrement takes the counter to 0.
- Undefined: no forwarding, behaviour as in Behaviour.

Decomposition:
- Package regfile_mp_pkg:
  - default width and count constants
  - function computing the maximum count from CNT_WIDTH
  - packed-port slicing helper functions
- Sub-module regfile_sb_counter: one CNT_WIDTH saturating up/down counter per register.
  - Inputs: inc, dec[1:0], flush.
  - Outputs: cnt, nonzero, at_max.
  - Instantiated NUM_REGS times via generate.

Test Plan:
- Reset then read all ports -> rd_data = 0, rd_busy = 0. Assert rst mid-run after writing R3 = 0x55 -> R3 reads 0 asynchronously.
- wb0 and wb1 both write R5 (0xAAAA0000 / 0x0000BBBB) in one cycle -> R5 = 0xAAAA0000. A same-cycle read of R5 returns the old value, or 0xAAAA0000 when the bypass macro is defined.
- Issue R2 three times (CNT_WIDTH = 2) -> rd_busy = 1, count 3. A fourth issue gives iss_full = 1 with count still 3. Three wb0 writes to R2 -> busy = 0 after the third.
- iss_en and wb0_en both to R7 with count 1 -> count stays 1, busy = 1, R7 updated.
- Issue R1 and R4, then flush while wb1 writes R4 = 0x1234 -> all counts 0, R4 = 0x1234.
- Write to index 15 with NUM_REGS = 15 -> no state change. Read of index 15 returns 0, busy 0.
